// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// The master drives operands and consumes results; the slave is the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid,
        output a,
        output b,
        output sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  carry,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output carry,
        output zero
    );

endinterface

// File: rtl/alu_seq.sv
// Registered 16-op ALU with valid/ready handshakes on both sides.
// MUL (shift-add) and DIV (restoring) retire one bit per cycle; all other ops finish on accept.
module alu_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpMul  = 4'b0010;
    localparam logic [3:0] OpDiv  = 4'b0011;
    localparam logic [3:0] OpShl  = 4'b0100;
    localparam logic [3:0] OpShr  = 4'b0101;
    localparam logic [3:0] OpRol  = 4'b0110;
    localparam logic [3:0] OpRor  = 4'b0111;
    localparam logic [3:0] OpAnd  = 4'b1000;
    localparam logic [3:0] OpOr   = 4'b1001;
    localparam logic [3:0] OpXor  = 4'b1010;
    localparam logic [3:0] OpNor  = 4'b1011;
    localparam logic [3:0] OpNand = 4'b1100;
    localparam logic [3:0] OpXnor = 4'b1101;
    localparam logic [3:0] OpGt   = 4'b1110;
    localparam logic [3:0] OpEq   = 4'b1111;

    // The accept edge already performs the first iteration, so WIDTH-1 remain.
    localparam logic [CW-1:0] IterLoad = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [SW:0]   WBits    = (SW + 1)'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             start_iter;

    logic [SW-1:0]    sh_n;
    logic [SW:0]      rot_back;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] rol_res;
    logic [WIDTH-1:0] ror_res;
    logic             gt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH-1:0] it_opnd;
    logic             it_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_rem;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign start_iter = (bus.sel == OpMul) || ((bus.sel == OpDiv) && (bus.b != '0));

    // Single-cycle datapath, evaluated straight off the incoming operands.
    always_comb begin
        sh_n     = bus.b[SW-1:0];
        rot_back = WBits - {1'b0, sh_n};
        add_ext  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_ext  = {1'b0, bus.a} - {1'b0, bus.b};
        shl_ext  = {1'b0, bus.a} << sh_n;
        shr_ext  = {bus.a, 1'b0} >> sh_n;
        rol_res  = (bus.a << sh_n) | (bus.a >> rot_back);
        ror_res  = (bus.a >> sh_n) | (bus.a << rot_back);
        if (SIGNED_CMP) begin
            gt = $signed(bus.a) > $signed(bus.b);
        end else begin
            gt = bus.a > bus.b;
        end

        alu_res   = '0;
        alu_carry = 1'b0;
        case (bus.sel)
            OpAdd: begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
            end
            OpSub: begin
                alu_res   = sub_ext[WIDTH-1:0];
                alu_carry = sub_ext[WIDTH];
            end
            // Only reaches the single-cycle path when the divisor is zero.
            OpDiv: begin
                alu_res   = '1;
                alu_carry = 1'b1;
            end
            OpShl: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = shl_ext[WIDTH];
            end
            OpShr: begin
                alu_res   = shr_ext[WIDTH:1];
                alu_carry = shr_ext[0];
            end
            OpRol:   alu_res = rol_res;
            OpRor:   alu_res = ror_res;
            OpAnd:   alu_res = bus.a & bus.b;
            OpOr:    alu_res = bus.a | bus.b;
            OpXor:   alu_res = bus.a ^ bus.b;
            OpNor:   alu_res = ~(bus.a | bus.b);
            OpNand:  alu_res = ~(bus.a & bus.b);
            OpXnor:  alu_res = ~(bus.a ^ bus.b);
            OpGt:    alu_res = {{(WIDTH - 1){1'b0}}, gt};
            OpEq:    alu_res = {{(WIDTH - 1){1'b0}}, (bus.a == bus.b)};
            default: alu_res = '0;
        endcase
    end

    // One shift-add / restoring-divide step. In IDLE the step runs on freshly
    // loaded operands; in BUSY it runs on the held partial state.
    always_comb begin
        if (state_q == StIdle) begin
            it_div  = (bus.sel == OpDiv);
            it_hi   = '0;
            it_lo   = it_div ? bus.a : bus.b;
            it_opnd = it_div ? bus.b : bus.a;
        end else begin
            it_div  = is_div_q;
            it_hi   = hi_q;
            it_lo   = lo_q;
            it_opnd = opnd_q;
        end

        mul_sum = {1'b0, it_hi} + (it_lo[0] ? {1'b0, it_opnd} : {(WIDTH + 1){1'b0}});
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], it_lo[WIDTH-1:1]};

        div_sh  = {it_hi, it_lo[WIDTH-1]};
        div_ok  = (div_sh >= {1'b0, it_opnd});
        div_rem = div_sh[WIDTH-1:0] - it_opnd;
        div_hi  = div_ok ? div_rem : div_sh[WIDTH-1:0];
        div_lo  = {it_lo[WIDTH-2:0], div_ok};

        step_hi = it_div ? div_hi : mul_hi;
        step_lo = it_div ? div_lo : mul_lo;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (start_iter) begin
                        hi_d     = step_hi;
                        lo_d     = step_lo;
                        opnd_d   = it_opnd;
                        is_div_d = it_div;
                        cnt_d    = IterLoad;
                        state_d  = StBusy;
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        zero_d   = (alu_res == '0);
                        state_d  = StDone;
                    end
                end
            end
            StBusy: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    // lo holds the product low half or the quotient; hi the product high half.
                    result_d = step_lo;
                    carry_d  = is_div_q ? 1'b0 : (|step_hi);
                    zero_d   = (step_lo == '0);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;

endmodule
